// File: rtl/seg7_scan_capture_if.sv
// Multiplexed 7-segment display bus as seen by the capture block:
// raw anode/segment lines in, recovered digits and status pulses out.
interface seg7_scan_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [NUM_DIGITS-1:0]   an;
  logic [7:0]              seg;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    frame_done;
  logic                    err;

  modport master (
    output an, seg,
    input  hex_out, dp_out, digit_valid, frame_done, err
  );

  modport slave (
    input  an, seg,
    output hex_out, dp_out, digit_valid, frame_done, err
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Samples an active-low multiplexed 7-segment bus and recovers the hex digit,
// DP state and glyph validity per position, with frame and error pulses.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_capture_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD,
    S_MULTI
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  // {ok, bad, hex}; blank (7F) is neither ok nor bad
  function automatic logic [5:0] decode_glyph(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h40: r = {2'b10, 4'h0};
      7'h79: r = {2'b10, 4'h1};
      7'h24: r = {2'b10, 4'h2};
      7'h30: r = {2'b10, 4'h3};
      7'h19: r = {2'b10, 4'h4};
      7'h12: r = {2'b10, 4'h5};
      7'h02: r = {2'b10, 4'h6};
      7'h78: r = {2'b10, 4'h7};
      7'h00: r = {2'b10, 4'h8};
      7'h10: r = {2'b10, 4'h9};
      7'h08: r = {2'b10, 4'hA};
      7'h03: r = {2'b10, 4'hB};
      7'h46: r = {2'b10, 4'hC};
      7'h21: r = {2'b10, 4'hD};
      7'h06: r = {2'b10, 4'hE};
      7'h0E: r = {2'b10, 4'hF};
      7'h7F: r = 6'b00_0000;
      default: r = 6'b01_0000;
    endcase
    return r;
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0]   r_an_p0, r_an_p1, r_an_p2;
  logic [7:0]              r_seg_p0, r_seg_p1, r_seg_p2;
  logic [NUM_DIGITS-1:0]   r_an_lat;
  logic [NUM_DIGITS-1:0]   r_mask;
  logic [7:0]              r_cnt;
  logic                    r_frame, r_err;
  logic [4*NUM_DIGITS-1:0] r_hex;
  logic [NUM_DIGITS-1:0]   r_dp, r_valid;

  logic                    w_an_idle, w_an_one, w_an_multi, w_stable;
  logic                    w_cnt_clr, w_cnt_inc, w_cap, w_err_multi;
  logic [5:0]              w_dec;
  logic [NUM_DIGITS-1:0]   w_sel, w_mask_nxt;
  logic                    w_full;

  // Stage p0/p1: two-flop synchronizer; p2: previous synchronized value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_p0  <= '1;
      r_an_p1  <= '1;
      r_an_p2  <= '1;
      r_seg_p0 <= '1;
      r_seg_p1 <= '1;
      r_seg_p2 <= '1;
    end else begin
      r_an_p0  <= bus.an;
      r_an_p1  <= r_an_p0;
      r_an_p2  <= r_an_p1;
      r_seg_p0 <= bus.seg;
      r_seg_p1 <= r_seg_p0;
      r_seg_p2 <= r_seg_p1;
    end
  end

  assign w_an_idle  = &r_an_p1;
  assign w_an_one   = $onehot(~r_an_p1);
  assign w_an_multi = !w_an_idle && !w_an_one;
  assign w_stable   = (r_an_p1 == r_an_p2) && (r_seg_p1 == r_seg_p2);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_an_one) begin
          w_state_nxt = S_SETTLE;
          w_cnt_clr   = 1'b1;
        end else if (w_an_multi) begin
          w_state_nxt = S_MULTI;
        end
      end
      S_SETTLE: begin
        if (!w_stable) begin
          w_cnt_clr = 1'b1;
          if (w_an_idle)       w_state_nxt = S_IDLE;
          else if (w_an_multi) w_state_nxt = S_MULTI;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_CAPTURE;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_cap       = 1'b1;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // segment changes are ignored until the anode moves on
        if (r_an_p1 != r_an_lat) begin
          if (w_an_one) begin
            w_state_nxt = S_SETTLE;
            w_cnt_clr   = 1'b1;
          end else if (w_an_idle) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_MULTI;
          end
        end
      end
      S_MULTI: begin
        if (w_an_one) begin
          w_state_nxt = S_SETTLE;
          w_cnt_clr   = 1'b1;
        end else if (w_an_idle) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_err_multi = (w_state_nxt == S_MULTI) && (r_state != S_MULTI);
  assign w_dec       = decode_glyph(r_seg_p2[6:0]);
  assign w_sel       = ~r_an_p2;
  assign w_mask_nxt  = r_mask | w_sel;
  assign w_full      = &w_mask_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mask   <= '0;
      r_an_lat <= '1;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
      if (w_cap) begin
        r_an_lat <= r_an_p2;
        r_mask   <= w_full ? '0 : w_mask_nxt;
      end
      r_frame <= w_cap && w_full;
      r_err   <= w_err_multi || (w_cap && w_dec[4]);
    end
  end

  // Capture stage: p2 still holds the settled values during CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex   <= '0;
      r_dp    <= '0;
      r_valid <= '0;
    end else if (w_cap) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_sel[i]) begin
          r_hex[4*i +: 4] <= w_dec[5] ? w_dec[3:0] : 4'h0;
          r_dp[i]         <= ~r_seg_p2[7];
          r_valid[i]      <= w_dec[5];
        end
      end
    end
  end

  assign bus.hex_out     = r_hex;
  assign bus.dp_out      = r_dp;
  assign bus.digit_valid = r_valid;
  assign bus.frame_done  = r_frame;
  assign bus.err         = r_err;

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the team's hex-to-7-segment decode path. This block samples a multiplexed, active-low 7-segment display bus (anode strobes plus shared segment lines) and recovers the hex digit and decimal-point state shown on each position. Per-digit valid flags, a frame-complete pulse and an error pulse are provided for display self-test and board-level loopback checks.

## Interface

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- SETTLE_CYCLES, 4, synchronized cycles that anode and segment lines must be stable before a capture (2..255).

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, asynchronous and active-low.
- an  in  NUM_DIGITS  anode strobes, active-low; bit i selects digit i.
- seg  in  8  segment lines, active-low.
  - seg[0]..seg[6] are segments a..g.
  - seg[7] is DP.
- hex_out  out  4*NUM_DIGITS  recovered digit i on bits [4i+3:4i].
- dp_out  out  NUM_DIGITS  1 = DP lit on digit i.
- digit_valid  out  NUM_DIGITS  1 = last capture of digit i matched a hex glyph.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the previous pulse.
- err  out  1  one-cycle pulse on a bad glyph or a multi-hot anode vector.

## Operation

- **Input synchronization.** an and seg each pass through a 2-flop synchronizer. Synchronizer reset value is all ones (inactive). All logic below uses the synchronized values.

- **Glyph table.** Lookup on seg[6:0] (g..a, active-low):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b, 46→C, 21→d, 06→E, 0E→F
  - 7F (blank) is legal: digit_valid[i]=0, hex field ← 0, no err.
  - Any other pattern: digit_valid[i]=0, hex field ← 0, err pulses.

- **FSM states**
  - IDLE:
    - an all ones → stay.
    - an one-hot-low → SETTLE, counter cleared.
    - an multi-hot-low → MULTI.
  - SETTLE: counter increments each cycle in which an and seg equal their previous-cycle values.
    - Any change → counter reset to 0. If an is still one-hot, stay in SETTLE; otherwise go to IDLE or MULTI.
    - Counter reaches SETTLE_CYCLES → CAPTURE.
  - CAPTURE (1 cycle): write hex field, dp_out[i] = ~seg[7] and digit_valid[i]; set captured_mask[i]; → HOLD.
  - HOLD: stay while an is unchanged; seg changes are ignored.
    - an changes to one-hot → SETTLE.
    - an changes to all ones → IDLE.
    - an changes to multi-hot → MULTI.
  - MULTI:
    - err pulses on the entry cycle only.
    - No captures while here.
    - Leave to IDLE or SETTLE when an becomes legal.

- **Frame tracking**
  - captured_mask has NUM_DIGITS bits.
  - When the CAPTURE write makes the mask all ones, frame_done pulses in that same cycle and the mask clears.
  - Recapturing a digit already in the mask does not pulse frame_done.

- **Capture data.** A digit's outputs change only on its own capture. Other digits hold their values.

## Timing

- **Reset values** (all asynchronous on rst_n low):
  - hex_out = 0, dp_out = 0, digit_valid = 0, frame_done = 0, err = 0.
  - State = IDLE, captured_mask = 0, counter = 0.
  - Synchronizers = all ones.
- **Capture latency.** A raw an/seg change held stable produces updated outputs exactly SETTLE_CYCLES+3 rising edges later.
- **Pulse timing.** frame_done and err are registered and exactly one cycle wide. They may assert in the same cycle, e.g. a bad glyph on the last digit of a frame.
- **Short strobes.** An anode window shorter than SETTLE_CYCLES+1 synchronized cycles is never captured and raises no err.
- **Reset mid-operation.** Capture is aborted and all state returns to reset values. No output pulses during or immediately after reset release.
- **Wrap-around.** Repeated frames with a free-running scan produce one frame_done per full scan. The mask must not carry over between frames.

## Test plan

- **Static scan.** NUM_DIGITS=4, SETTLE_CYCLES=4. Scan digits 0..3 with glyphs 0x30, 0x08, 0x46, 0x0E, DP on digit 1 only, 16 cycles per digit → hex_out=16'hFCA3, dp_out=4'b0010, digit_valid=4'hF. frame_done pulses once, at the digit-3 capture.
- **Latency.** Anode 2 goes low with glyph 0x12 at edge 0 → hex_out[11:8]=5 first visible after edge 7, no earlier.
- **Glitch rejection.**
  - seg toggles every 3 cycles during an anode-1 window → no capture.
  - Glyph then held 10 cycles → single capture.
  - 3-cycle anode pulse → no change, no err.
- **Errors.**
  - Glyph 0x55 on digit 0 → err 1 cycle, digit_valid[0]=0, hex_out[3:0]=0.
  - an=4'b1001 held 20 cycles → exactly one err, no captures.
- **Blank.** Glyph 0x7F on digit 3 → digit_valid[3]=0, no err, and frame completion still counts digit 3.
- **Reset mid-operation.** Assert rst_n low mid-SETTLE of the third digit, release, then rescan all 4 digits → all outputs are reset values during reset. Exactly one frame_done after the 4 post-reset captures.
